// File: rtl/renkon_linebuf_ctrl.sv
// renkon_linebuf_ctrl: sliding-window generator for the renkon convolution engine.
// Takes a raster-order pixel stream and keeps the most recent FSIZE-1 rows in FSIZE
// rotating single-port line memories. Each accepted pixel yields one FSIZE x FSIZE window
// column, which shifts into a window register presented to the MAC array.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   buf_req       frame start pulse, honoured only while idle
//   img_width     row length in pixels, latched on an accepted buf_req
//   img_height    row count, latched on an accepted buf_req
//   buf_ack       high while idle (ready / frame done)
//   pixel_valid   input pixel qualifier
//   pixel_data    signed input pixel
//   pixel_ready   block accepts a pixel (transfer on valid && ready)
//   win_valid     single-cycle pulse: win_data holds a complete window
//   win_data      window; slice (i*FSIZE+j)*DWIDTH is row i (0 = top), column j (0 = left)
module renkon_linebuf_ctrl #(
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned BUFSIZE = 8,
  parameter int unsigned FSIZE   = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              buf_req,
  input  logic [BUFSIZE:0]                  img_width,
  input  logic [BUFSIZE:0]                  img_height,
  output logic                              buf_ack,
  input  logic                              pixel_valid,
  input  logic signed [DWIDTH-1:0]          pixel_data,
  output logic                              pixel_ready,
  output logic                              win_valid,
  output logic [FSIZE*FSIZE*DWIDTH-1:0]     win_data
);

  localparam int unsigned SelW  = (FSIZE > 1) ? $clog2(FSIZE) : 1;
  localparam int unsigned Depth = 2 ** BUFSIZE;

  localparam logic [SelW-1:0]    SelLast = SelW'(FSIZE - 1);
  localparam logic [SelW-1:0]    SelOne  = SelW'(1);
  localparam logic [BUFSIZE-1:0] ColOne  = BUFSIZE'(1);
  localparam logic [BUFSIZE-1:0] ColMin  = BUFSIZE'(FSIZE - 1);
  localparam logic [BUFSIZE:0]   DimOne  = (BUFSIZE + 1)'(1);
  localparam logic [BUFSIZE:0]   RowMin  = (BUFSIZE + 1)'(FSIZE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_t;

  state_t state_q, state_d;

  logic [BUFSIZE:0]   width_q, height_q;
  logic [BUFSIZE-1:0] col_q;
  logic [BUFSIZE:0]   row_q;
  logic [SelW-1:0]    wr_sel_q;
  logic               flush_cnt_q;

  logic start, fire, last_col, last_row, win_ok;

  assign start    = (state_q == StIdle) && buf_req;
  assign fire     = pixel_valid && pixel_ready;
  assign last_col = ({1'b0, col_q} == (width_q - DimOne));
  assign last_row = (row_q == (height_q - DimOne));
  assign win_ok   = (row_q >= RowMin) && (col_q >= ColMin);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (buf_req) state_d = StRun;
      StRun:   if (fire && last_col && last_row) state_d = StFlush;
      StFlush: if (flush_cnt_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_ack     = (state_q == StIdle);
    pixel_ready = (state_q == StRun);
  end

  // ---------------------------------------------------------------------------
  // Frame counters and rotation pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      wr_sel_q    <= '0;
      flush_cnt_q <= 1'b0;
    end else begin
      // Two flush cycles: counter reads 0 on the first, 1 on the second.
      flush_cnt_q <= (state_q == StFlush);
      if (start) begin
        width_q  <= img_width;
        height_q <= img_height;
        col_q    <= '0;
        row_q    <= '0;
        wr_sel_q <= '0;
      end else if (fire) begin
        if (last_col) begin
          col_q    <= '0;
          row_q    <= row_q + DimOne;
          wr_sel_q <= (wr_sel_q == SelLast) ? '0 : (wr_sel_q + SelOne);
        end else begin
          col_q <= col_q + ColOne;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line memories: the selected one is written, all others read at the same
  // column. Read data is valid the cycle after the address.
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] rd_data [FSIZE];

  for (genvar k = 0; k < FSIZE; k++) begin : g_mem
    logic [DWIDTH-1:0] mem [Depth];
    logic [DWIDTH-1:0] rd_q;
    logic              we;

    assign we = fire && (wr_sel_q == SelW'(k));

    always_ff @(posedge clk) begin
      if (we) begin
        mem[col_q] <= pixel_data;
      end else if (fire) begin
        rd_q <= mem[col_q];
      end
    end

    assign rd_data[k] = rd_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: current pixel and rotation pointer aligned with memory read data
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] px_q;
  logic [SelW-1:0]   sel_q;
  logic              s1_valid_q, s1_win_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q       <= '0;
      sel_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_win_q   <= 1'b0;
    end else begin
      s1_valid_q <= fire;
      if (fire) begin
        px_q     <= pixel_data;
        sel_q    <= wr_sel_q;
        s1_win_q <= win_ok;
      end
    end
  end

  // Oldest row lives in the memory just after the one being written.
  logic [DWIDTH-1:0] col_vec [FSIZE];

  always_comb begin
    for (int i = 0; i < FSIZE; i++) begin
      col_vec[i] = '0;
    end
    for (int i = 0; i < FSIZE - 1; i++) begin
      for (int k = 0; k < FSIZE; k++) begin
        if (k == (int'(sel_q) + 1 + i) % int'(FSIZE)) begin
          col_vec[i] = rd_data[k];
        end
      end
    end
    col_vec[FSIZE-1] = px_q;
  end

  // ---------------------------------------------------------------------------
  // Window register: new column enters on the right, column 0 is oldest
  // ---------------------------------------------------------------------------
  logic [DWIDTH-1:0] win_q [FSIZE][FSIZE];
  logic              win_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      for (int i = 0; i < FSIZE; i++) begin
        for (int j = 0; j < FSIZE; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      win_valid_q <= s1_valid_q && s1_win_q;
      if (s1_valid_q) begin
        for (int i = 0; i < FSIZE; i++) begin
          for (int j = 0; j < FSIZE - 1; j++) begin
            win_q[i][j] <= win_q[i][j+1];
          end
          win_q[i][FSIZE-1] <= col_vec[i];
        end
      end
    end
  end

  always_comb begin
    win_valid = win_valid_q;
    win_data  = '0;
    for (int i = 0; i < FSIZE; i++) begin
      for (int j = 0; j < FSIZE; j++) begin
        win_data[(i*FSIZE+j)*DWIDTH +: DWIDTH] = win_q[i][j];
      end
    end
  end

endmodule

// File: tb/tb_renkon_linebuf_ctrl.sv
// Bench for renkon_linebuf_ctrl: table of frames with hand-computed window counts and
// corner slices, plus an image-level window model and hand-written reset sequence.
module tb_renkon_linebuf_ctrl;
  localparam int DW = 16;
  localparam int BS = 8;
  localparam int FS = 5;
  localparam int WB = FS * FS * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            buf_req;
  logic [BS:0]     img_width, img_height;
  logic            buf_ack;
  logic            pixel_valid;
  logic [DW-1:0]   pixel_data;
  logic            pixel_ready;
  logic            win_valid;
  logic [WB-1:0]   win_data;

  renkon_linebuf_ctrl #(
    .DWIDTH (DW),
    .BUFSIZE(BS),
    .FSIZE  (FS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .buf_req    (buf_req),
    .img_width  (img_width),
    .img_height (img_height),
    .buf_ack    (buf_ack),
    .pixel_valid(pixel_valid),
    .pixel_data (pixel_data),
    .pixel_ready(pixel_ready),
    .win_valid  (win_valid),
    .win_data   (win_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Window monitor, sampled on the falling edge.
  int          win_cyc_q[$];
  logic [WB-1:0] win_dat_q[$];
  int          exp_cyc_q[$];

  always @(negedge clk) begin
    if (win_valid) begin
      win_cyc_q.push_back(cyc);
      win_dat_q.push_back(win_data);
    end
  end

  int checks = 0;
  int failures = 0;

  typedef struct {
    int w, h, base;
    bit rnd, hold;
    int nwin, f0, f24, l0, l24;
  } vec_t;

  vec_t tbl[6];
  vec_t post;

  function automatic vec_t mk(input int w, input int h, input int base, input bit rnd,
                              input bit hold, input int nwin, input int f0, input int f24,
                              input int l0, input int l24);
    vec_t v;
    v.w = w; v.h = h; v.base = base; v.rnd = rnd; v.hold = hold;
    v.nwin = nwin; v.f0 = f0; v.f24 = f24; v.l0 = l0; v.l24 = l24;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input int idx, input logic [WB-1:0] act,
                        input logic [WB-1:0] exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int base, input int r, input int c);
    int v;
    v = base + 16 * r + c;
    return v[DW-1:0];
  endfunction

  function automatic int sl(input logic [WB-1:0] d, input int k);
    logic signed [DW-1:0] s;
    s = d[k*DW +: DW];
    return int'(s);
  endfunction

  // Window whose bottom-right pixel is (r, c), built straight from the image.
  function automatic logic [WB-1:0] model_win(input int base, input int r, input int c);
    logic [WB-1:0] w;
    w = '0;
    for (int i = 0; i < FS; i++) begin
      for (int j = 0; j < FS; j++) begin
        w[(i*FS+j)*DW +: DW] = pix(base, r - FS + 1 + i, c - FS + 1 + j);
      end
    end
    return w;
  endfunction

  // Drives one frame; stops early after accepting (stop_r, stop_c) if given.
  task automatic run_frame(input int w, input int h, input int base, input bit rnd,
                           input bit hold, input int stop_r, input int stop_c,
                           output int sent, output int last_acc);
    int  r, c, guard;
    bit  acc, stop;
    @(negedge clk);
    buf_req    = 1'b1;
    img_width  = (BS+1)'(w);
    img_height = (BS+1)'(h);
    @(negedge clk);
    check("start pixel_ready", int'(pixel_ready), 1);
    check("start buf_ack", int'(buf_ack), 0);
    if (hold) begin
      // Keep requesting with bogus dimensions; must be ignored while running.
      img_width  = (BS+1)'(3);
      img_height = (BS+1)'(3);
    end else begin
      buf_req = 1'b0;
    end
    sent = 0; r = 0; c = 0; guard = 0; last_acc = -1;
    while (sent < w * h && guard < 20 * w * h + 100) begin
      pixel_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pixel_data  = pix(base, r, c);
      acc  = pixel_valid && pixel_ready;
      stop = (r == stop_r) && (c == stop_c);
      if (acc) begin
        if (r >= FS - 1 && c >= FS - 1) exp_cyc_q.push_back(cyc + 2);
        last_acc = cyc;
        sent++;
      end
      @(negedge clk);
      guard++;
      if (acc) begin
        if (c == w - 1) begin
          c = 0;
          r++;
        end else begin
          c++;
        end
        if (stop) break;
      end
    end
    pixel_valid = 1'b0;
    buf_req     = 1'b0;
  endtask

  task automatic wait_ack(input string tag, input int last_acc);
    int g;
    g = 0;
    while (!buf_ack && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, " buf_ack latency"}, buf_ack ? cyc - last_acc : -1, 3);
  endtask

  task automatic do_frame(input vec_t v, input string tag);
    int sent, last_acc, nwin, span, f0, rr, cc;
    win_cyc_q.delete();
    win_dat_q.delete();
    exp_cyc_q.delete();
    run_frame(v.w, v.h, v.base, v.rnd, v.hold, -1, -1, sent, last_acc);
    check({tag, " pixels accepted"}, sent, v.w * v.h);
    wait_ack(tag, last_acc);
    repeat (3) @(negedge clk);
    nwin = win_cyc_q.size();
    check({tag, " window count"}, nwin, v.nwin);
    if (nwin > 0) begin
      check({tag, " first slice0"}, sl(win_dat_q[0], 0), v.f0);
      check({tag, " first slice24"}, sl(win_dat_q[0], 24), v.f24);
      check({tag, " last slice0"}, sl(win_dat_q[nwin-1], 0), v.l0);
      check({tag, " last slice24"}, sl(win_dat_q[nwin-1], 24), v.l24);
    end
    span = v.w - FS + 1;
    f0 = failures;
    for (int k = 0; k < nwin && k < v.nwin && failures - f0 < 4; k++) begin
      rr = FS - 1 + k / span;
      cc = FS - 1 + k % span;
      checkw({tag, " window"}, k, win_dat_q[k], model_win(v.base, rr, cc));
      if (k < exp_cyc_q.size()) check({tag, " window cycle"}, win_cyc_q[k], exp_cyc_q[k]);
    end
  endtask

  initial begin
    int sent, last_acc;
    rst         = 1'b1;
    buf_req     = 1'b0;
    img_width   = '0;
    img_height  = '0;
    pixel_valid = 1'b0;
    pixel_data  = '0;

    //               w    h   base  rnd hold nwin  f0    f24   l0    l24
    tbl[0] = mk(8,   6,   0,    0,  0,   8,    0,    68,   19,   87);
    tbl[1] = mk(8,   6,   0,    1,  0,   8,    0,    68,   19,   87);
    tbl[2] = mk(256, 5,   0,    0,  0,   252,  0,    68,   251,  319);
    tbl[3] = mk(4,   10,  0,    0,  0,   0,    0,    0,    0,    0);
    tbl[4] = mk(6,   7,   1000, 0,  1,   6,    1000, 1068, 1033, 1101);
    tbl[5] = mk(9,   5,   -300, 0,  0,   5,    -300, -232, -296, -228);
    post   = mk(5,   5,   500,  0,  0,   1,    500,  568,  500,  568);

    repeat (2) @(negedge clk);
    check("reset buf_ack", int'(buf_ack), 1);
    check("reset pixel_ready", int'(pixel_ready), 0);
    check("reset win_valid", int'(win_valid), 0);
    check("reset win_data zero", int'(win_data == '0), 1);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_frame(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a frame, then a clean 5x5 frame.
    win_cyc_q.delete();
    win_dat_q.delete();
    exp_cyc_q.delete();
    run_frame(8, 8, 0, 1'b0, 1'b0, 3, 2, sent, last_acc);
    check("midrst pixels before reset", sent, 27);
    rst = 1'b1;
    #1;
    check("midrst buf_ack", int'(buf_ack), 1);
    check("midrst pixel_ready", int'(pixel_ready), 0);
    check("midrst win_valid", int'(win_valid), 0);
    check("midrst win_data zero", int'(win_data == '0), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst no window", win_cyc_q.size(), 0);
    do_frame(post, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
